// File: rtl/md5_pkg.sv
// -----------------------------------------------------------------------------
// md5_pkg
// Shared constants and types for the MD5 message front end and PE variants.
//   BLOCK_BYTES : bytes per MD5 block (64)
//   BLOCK_W     : bits per MD5 block (512)
//   LEN_OFFSET  : byte position of the 64-bit little-endian length field
//   PAD_BYTE    : first padding byte (0x80)
//   state_e     : padder FSM states
// -----------------------------------------------------------------------------
package md5_pkg;

    localparam int BLOCK_BYTES = 64;
    localparam int BLOCK_W     = BLOCK_BYTES * 8;
    localparam int LEN_OFFSET  = 56;
    localparam int LEN_BITS    = 64;

    localparam logic [7:0] PAD_BYTE = 8'h80;

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_PAD  = 2'd1,
        S_XTRA = 2'd2,
        S_EMIT = 2'd3
    } state_e;

    // Place a 64-bit length into bytes 56..63 of a block. Byte k lives at
    // bits [8k+7:8k], so a little-endian length is simply the top 64 bits.
    function automatic logic [BLOCK_W-1:0] put_len(
        input logic [BLOCK_W-1:0]  blk,
        input logic [LEN_BITS-1:0] len
    );
        logic [BLOCK_W-1:0] r;
        r = blk;
        r[BLOCK_W-1 -: LEN_BITS] = len;
        return r;
    endfunction

endpackage : md5_pkg

// File: rtl/md5_len_counter.sv
// -----------------------------------------------------------------------------
// md5_len_counter
// Message bit-length counter. Advances by 8 for every message byte, wraps
// modulo 2^LEN_W, and clears synchronously at the end of a message.
// Ports:
//   clk_i   : clock
//   rst_ni  : asynchronous active-low reset (clears the count)
//   clr_i   : synchronous clear (wins over inc_i)
//   inc_i   : add 8 this cycle
//   cnt_o   : current bit count (registered)
// -----------------------------------------------------------------------------
module md5_len_counter #(
    parameter int LEN_W = 64
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [LEN_W-1:0] cnt_o
);

    localparam logic [LEN_W-1:0] STEP = {{(LEN_W-4){1'b0}}, 4'd8};

    logic [LEN_W-1:0] cnt_q;

    // Bit counter register: clear has priority, otherwise add one byte's worth.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (inc_i) begin
            cnt_q <= cnt_q + STEP;
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign cnt_o = cnt_q;

endmodule : md5_len_counter

// File: rtl/md5_msg_padder.sv
// -----------------------------------------------------------------------------
// md5_msg_padder
// Accepts a raw message as a byte stream, applies MD5 padding (0x80, zero
// fill, 64-bit little-endian bit length) and hands complete 512-bit blocks to
// the MD5 PE over a valid/ready handshake.
// Ports:
//   Clk, Rst_n  : clock, asynchronous active-low reset
//   byte_valid  : input beat valid
//   byte_data   : message byte
//   byte_keep   : beat carries a byte (0 = empty beat, only useful with last)
//   byte_last   : final beat of the message
//   byte_ready  : padder accepts a beat this cycle
//   blk_valid   : blk_data holds a complete block
//   blk_data    : block, message byte k at [8k+7:8k]
//   blk_last    : final block of the message (carries the length field)
//   blk_ready   : PE accepts the block
//   busy        : message in progress
// -----------------------------------------------------------------------------
module md5_msg_padder
    import md5_pkg::*;
#(
    parameter int LEN_W       = 64,
    parameter int BLOCK_BYTES = 64
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic                 byte_valid,
    input  logic [7:0]           byte_data,
    input  logic                 byte_keep,
    input  logic                 byte_last,
    output logic                 byte_ready,
    output logic                 blk_valid,
    output logic [BLOCK_W-1:0]   blk_data,
    output logic                 blk_last,
    input  logic                 blk_ready,
    output logic                 busy
);

    localparam int IDX_W = $clog2(BLOCK_BYTES);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(BLOCK_BYTES - 1);
    localparam logic [IDX_W-1:0] IDX_LEN_MAX = IDX_W'(LEN_OFFSET - 1);
    localparam logic [IDX_W-1:0] IDX_ONE     = {{(IDX_W-1){1'b0}}, 1'b1};

    state_e               state_q, state_d;
    state_e               next_q, next_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [BLOCK_W-1:0]   buf_q, buf_d;
    logic                 last_q, last_d;
    logic                 busy_q, busy_d;
    logic                 byte_ready_q, byte_ready_d;
    logic                 blk_valid_q, blk_valid_d;

    logic                 beat_xfer_s;
    logic                 blk_xfer_s;
    logic                 cnt_inc_s;
    logic                 cnt_clr_s;
    logic [LEN_W-1:0]     bitcnt_s;
    logic [LEN_BITS-1:0]  len_s;

    md5_len_counter #(
        .LEN_W (LEN_W)
    ) u_len_counter (
        .clk_i  (Clk),
        .rst_ni (Rst_n),
        .clr_i  (cnt_clr_s),
        .inc_i  (cnt_inc_s),
        .cnt_o  (bitcnt_s)
    );

    // Length field: counter zero-extended to 64 bits.
    always_comb begin
        len_s = LEN_BITS'(bitcnt_s);
    end

    // Next-state, buffer and output decode for the padder FSM.
    always_comb begin
        state_d   = state_q;
        next_d    = next_q;
        idx_d     = idx_q;
        buf_d     = buf_q;
        last_d    = last_q;
        busy_d    = busy_q;
        cnt_inc_s = 1'b0;
        cnt_clr_s = 1'b0;

        // byte_ready_q is only ever high while in S_FILL.
        beat_xfer_s = byte_valid & byte_ready_q;
        blk_xfer_s  = blk_valid_q & blk_ready;

        case (state_q)
            S_FILL: begin
                if (beat_xfer_s) begin
                    busy_d = 1'b1;
                    if (byte_keep) begin
                        buf_d[{idx_q, 3'b000} +: 8] = byte_data;
                        idx_d     = idx_q + IDX_ONE;
                        cnt_inc_s = 1'b1;
                        if (idx_q == IDX_LAST) begin
                            // Full data block: ship it first, pad afterwards
                            // if this was also the final byte.
                            state_d = S_EMIT;
                            last_d  = 1'b0;
                            next_d  = byte_last ? S_PAD : S_FILL;
                        end else if (byte_last) begin
                            state_d = S_PAD;
                        end else begin
                            state_d = S_FILL;
                        end
                    end else if (byte_last) begin
                        state_d = S_PAD;
                    end else begin
                        // Empty beat without last: accepted and ignored.
                        state_d = S_FILL;
                    end
                end else begin
                    state_d = S_FILL;
                end
            end

            S_PAD: begin
                for (int k = 0; k < BLOCK_BYTES; k++) begin
                    if (k == int'(idx_q)) begin
                        buf_d[k*8 +: 8] = PAD_BYTE;
                    end else if (k > int'(idx_q)) begin
                        buf_d[k*8 +: 8] = 8'h00;
                    end else begin
                        buf_d[k*8 +: 8] = buf_q[k*8 +: 8];
                    end
                end
                if (idx_q <= IDX_LEN_MAX) begin
                    // Length fits behind the 0x80 in this block.
                    buf_d  = put_len(buf_d, len_s);
                    last_d = 1'b1;
                    next_d = S_FILL;
                end else begin
                    // No room for the length: it goes into an extra block.
                    last_d = 1'b0;
                    next_d = S_XTRA;
                end
                state_d = S_EMIT;
            end

            S_XTRA: begin
                buf_d   = put_len({BLOCK_W{1'b0}}, len_s);
                last_d  = 1'b1;
                next_d  = S_FILL;
                state_d = S_EMIT;
            end

            S_EMIT: begin
                if (blk_xfer_s) begin
                    state_d = next_q;
                    idx_d   = '0;
                    if (last_q && (next_q == S_FILL)) begin
                        // Message complete: restart length for the next one.
                        cnt_clr_s = 1'b1;
                        busy_d    = 1'b0;
                    end else begin
                        busy_d = busy_q;
                    end
                end else begin
                    state_d = S_EMIT;
                end
            end

            default: begin
                state_d = S_FILL;
                idx_d   = '0;
            end
        endcase

        byte_ready_d = (state_d == S_FILL);
        blk_valid_d  = (state_d == S_EMIT);
    end

    // FSM and datapath registers; handshake outputs are registered decodes
    // of the next state so they are low throughout reset.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q      <= S_FILL;
            next_q       <= S_FILL;
            idx_q        <= '0;
            buf_q        <= '0;
            last_q       <= 1'b0;
            busy_q       <= 1'b0;
            byte_ready_q <= 1'b0;
            blk_valid_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            next_q       <= next_d;
            idx_q        <= idx_d;
            buf_q        <= buf_d;
            last_q       <= last_d;
            busy_q       <= busy_d;
            byte_ready_q <= byte_ready_d;
            blk_valid_q  <= blk_valid_d;
        end
    end

    assign byte_ready = byte_ready_q;
    assign blk_valid  = blk_valid_q;
    assign blk_data   = buf_q;
    assign blk_last   = last_q;
    assign busy       = busy_q;

endmodule : md5_msg_padder

// File: tb/tb_md5_msg_padder.sv
// -----------------------------------------------------------------------------
// tb_md5_msg_padder
// Directed bench for md5_msg_padder with hand-computed expected blocks.
// -----------------------------------------------------------------------------
module tb_md5_msg_padder;

    logic         Clk;
    logic         Rst_n;
    logic         byte_valid;
    logic [7:0]   byte_data;
    logic         byte_keep;
    logic         byte_last;
    logic         byte_ready;
    logic         blk_valid;
    logic [511:0] blk_data;
    logic         blk_last;
    logic         blk_ready;
    logic         busy;

    int n_checks = 0;
    int n_pass   = 0;

    md5_msg_padder #(
        .LEN_W       (64),
        .BLOCK_BYTES (64)
    ) dut (
        .Clk        (Clk),
        .Rst_n      (Rst_n),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_keep  (byte_keep),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .blk_valid  (blk_valid),
        .blk_data   (blk_data),
        .blk_last   (blk_last),
        .blk_ready  (blk_ready),
        .busy       (busy)
    );

    always #5 Clk = ~Clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic chk(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [511:0] set_byte(input logic [511:0] b, input int k, input logic [7:0] v);
        logic [511:0] r;
        r = b;
        r[k*8 +: 8] = v;
        return r;
    endfunction

    // Present one beat (called #1 after a rising edge) and hold it until taken.
    task automatic send_beat(input logic [7:0] d, input logic k, input logic l);
        int n;
        n = 0;
        byte_valid = 1'b1;
        byte_data  = d;
        byte_keep  = k;
        byte_last  = l;
        while (byte_ready !== 1'b1 && n < 200) begin
            @(posedge Clk); #1;
            n++;
        end
        if (n >= 200) chk("beat_wait_timeout", 512'(n), 512'd0);
        @(posedge Clk); #1;
        byte_valid = 1'b0;
        byte_keep  = 1'b0;
        byte_last  = 1'b0;
    endtask

    // Wait for a block, hold it off for 'hold' cycles checking stability,
    // then take it in a single transfer.
    task automatic get_block(input string tag, input int hold,
                             input logic [511:0] exp_d, input logic exp_l);
        int n;
        logic [511:0] d0;
        logic         l0;
        n = 0;
        blk_ready = 1'b0;
        while (blk_valid !== 1'b1 && n < 200) begin
            @(posedge Clk); #1;
            n++;
        end
        if (n >= 200) chk({tag, "_wait_timeout"}, 512'(n), 512'd0);
        d0 = blk_data;
        l0 = blk_last;
        chk({tag, "_data"}, d0, exp_d);
        chk({tag, "_last"}, 512'(l0), 512'(exp_l));
        for (int i = 0; i < hold; i++) begin
            @(posedge Clk); #1;
            chk({tag, "_hold_valid"}, 512'(blk_valid), 512'd1);
            chk({tag, "_hold_data"}, blk_data, d0);
            chk({tag, "_hold_last"}, 512'(blk_last), 512'(l0));
            chk({tag, "_hold_bready"}, 512'(byte_ready), 512'd0);
        end
        blk_ready = 1'b1;
        @(posedge Clk); #1;
        blk_ready = 1'b0;
        chk({tag, "_after_xfer_valid"}, 512'(blk_valid), 512'd0);
    endtask

    task automatic send_abc();
        send_beat(8'h61, 1'b1, 1'b0);
        send_beat(8'h62, 1'b1, 1'b0);
        send_beat(8'h63, 1'b1, 1'b1);
    endtask

    logic [511:0] abc_exp;
    logic [511:0] exp_a;
    logic [511:0] exp_b;

    initial begin
        Clk        = 1'b0;
        Rst_n      = 1'b0;
        byte_valid = 1'b0;
        byte_data  = 8'h00;
        byte_keep  = 1'b0;
        byte_last  = 1'b0;
        blk_ready  = 1'b0;

        // "abc": 61 62 63 80, length 24 bits = 0x18 at byte 56.
        abc_exp = '0;
        abc_exp = set_byte(abc_exp, 0, 8'h61);
        abc_exp = set_byte(abc_exp, 1, 8'h62);
        abc_exp = set_byte(abc_exp, 2, 8'h63);
        abc_exp = set_byte(abc_exp, 3, 8'h80);
        abc_exp = set_byte(abc_exp, 56, 8'h18);

        // Reset state
        #2;
        chk("rst_blk_valid", 512'(blk_valid), 512'd0);
        chk("rst_blk_last", 512'(blk_last), 512'd0);
        chk("rst_blk_data", blk_data, 512'd0);
        chk("rst_busy", 512'(busy), 512'd0);
        chk("rst_byte_ready", 512'(byte_ready), 512'd0);
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        chk("ready_after_rst", 512'(byte_ready), 512'd1);

        // Empty message
        send_beat(8'h00, 1'b0, 1'b1);
        chk("empty_busy", 512'(busy), 512'd1);
        exp_a = set_byte(512'd0, 0, 8'h80);
        get_block("empty", 0, exp_a, 1'b1);
        chk("empty_busy_done", 512'(busy), 512'd0);

        // "abc" with latency check
        send_beat(8'h61, 1'b1, 1'b0);
        chk("abc_busy", 512'(busy), 512'd1);
        send_beat(8'h62, 1'b1, 1'b0);
        send_beat(8'h63, 1'b1, 1'b1);
        chk("abc_lat_t", 512'(blk_valid), 512'd0);
        chk("abc_lat_bready", 512'(byte_ready), 512'd0);
        @(posedge Clk); #1;
        chk("abc_lat_t1", 512'(blk_valid), 512'd1);
        get_block("abc", 0, abc_exp, 1'b1);
        chk("abc_busy_done", 512'(busy), 512'd0);

        // "abc" with 5 cycles of backpressure
        send_abc();
        get_block("abc_bp", 5, abc_exp, 1'b1);

        // Empty beat without last in the middle is ignored
        send_beat(8'h61, 1'b1, 1'b0);
        send_beat(8'hEE, 1'b0, 1'b0);
        send_beat(8'h62, 1'b1, 1'b0);
        send_beat(8'h63, 1'b1, 1'b1);
        get_block("abc_gap", 0, abc_exp, 1'b1);

        // 56 bytes of 0x41: 448 bits = 0x1C0 in the extra block
        for (int i = 0; i < 56; i++) send_beat(8'h41, 1'b1, (i == 55));
        exp_a = '0;
        for (int i = 0; i < 56; i++) exp_a = set_byte(exp_a, i, 8'h41);
        exp_a = set_byte(exp_a, 56, 8'h80);
        exp_b = '0;
        exp_b = set_byte(exp_b, 56, 8'hC0);
        exp_b = set_byte(exp_b, 57, 8'h01);
        get_block("b56_blk1", 0, exp_a, 1'b0);
        get_block("b56_blk2", 0, exp_b, 1'b1);

        // 64 bytes 0x00..0x3F: 512 bits = 0x200
        for (int i = 0; i < 64; i++) send_beat(8'(i), 1'b1, (i == 63));
        chk("b64_valid_next", 512'(blk_valid), 512'd1);
        chk("b64_bready", 512'(byte_ready), 512'd0);
        exp_a = '0;
        for (int i = 0; i < 64; i++) exp_a = set_byte(exp_a, i, 8'(i));
        exp_b = set_byte(512'd0, 0, 8'h80);
        exp_b = set_byte(exp_b, 57, 8'h02);
        get_block("b64_blk1", 0, exp_a, 1'b0);
        get_block("b64_blk2", 0, exp_b, 1'b1);

        // Reset mid-message discards progress
        for (int i = 0; i < 10; i++) send_beat(8'h30 + 8'(i), 1'b1, 1'b0);
        chk("mid_busy", 512'(busy), 512'd1);
        Rst_n = 1'b0;
        @(posedge Clk); #1;
        @(posedge Clk); #1;
        chk("mid_rst_busy", 512'(busy), 512'd0);
        chk("mid_rst_valid", 512'(blk_valid), 512'd0);
        Rst_n = 1'b1;
        send_abc();
        get_block("mid_abc", 0, abc_exp, 1'b1);
        chk("mid_busy_done", 512'(busy), 512'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_md5_msg_padder
